// File: rtl/rom_burst_arbiter_pkg.sv
// rom_ctrl_pkg: shared constants and state encoding for the ROM burst arbiter.
//   ADDR_W - ROM address width (matches rom_us add)
//   DATA_W - ROM data width
//   LEN_W  - burst length field width; a burst is len+1 bytes
//   DEPTH  - populated ROM words, only consulted when ROM_ADDR_CHECK_EN is defined
package rom_ctrl_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int DEPTH  = 256;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

endpackage

// File: rtl/rom_burst_arbiter_if.sv
// rom_burst_arbiter_if: bundles the two requester ports, the rom_us pins and
// the read-return channel of rom_burst_arbiter.
//   req0/addr0/len0 -> gnt0 : port-0 burst request and one-cycle accept pulse
//   req1/addr1/len1 -> gnt1 : port-1 burst request and one-cycle accept pulse
//   rom_add/rom_read_en/rom_chip, rom_dato : rom_us pins (dato is combinational)
//   rd_data/rd_valid/rd_id/rd_last         : returned bytes, tagged by owner
//   busy                                   : arbiter is streaming a burst
//   err (only with ROM_ADDR_CHECK_EN)      : sticky out-of-range address flag
// Modports: slave = the arbiter, master = requesters/consumers/ROM side.
interface rom_burst_arbiter_if;
  import rom_ctrl_pkg::*;

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [LEN_W-1:0]  len0;
  logic              gnt0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [LEN_W-1:0]  len1;
  logic              gnt1;
  logic [ADDR_W-1:0] rom_add;
  logic              rom_read_en;
  logic              rom_chip;
  logic [DATA_W-1:0] rom_dato;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_id;
  logic              rd_last;
  logic              busy;
`ifdef ROM_ADDR_CHECK_EN
  logic              err;
`endif

  modport slave (
    input  req0, addr0, len0, req1, addr1, len1, rom_dato,
    output gnt0, gnt1, rom_add, rom_read_en, rom_chip,
           rd_data, rd_valid, rd_id, rd_last, busy
`ifdef ROM_ADDR_CHECK_EN
    , output err
`endif
  );

  modport master (
    output req0, addr0, len0, req1, addr1, len1, rom_dato,
    input  gnt0, gnt1, rom_add, rom_read_en, rom_chip,
           rd_data, rd_valid, rd_id, rd_last, busy
`ifdef ROM_ADDR_CHECK_EN
    , input err
`endif
  );

endinterface

// File: rtl/rom_burst_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
//   clk, rst   : clock, asynchronous active-high reset
//   i_req      : request vector {port1, port0}
//   i_advance  : strobe; records the currently granted port as last served
//   o_grant    : one-hot grant (combinational from i_req and last-served)
//   o_last     : last-served flag (1 = port 1 served last)
// After reset port 0 has priority, i.e. port 1 counts as served last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant,
  output logic       o_last
);

  logic r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_advance) begin
      r_last <= o_grant[1];
    end
  end

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  assign o_last = r_last;

endmodule

// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter: shares one rom_us between two burst requesters.
//   clk, rst : clock, asynchronous active-high reset (all outputs cleared)
//   bus      : rom_burst_arbiter_if.slave (requests, ROM pins, read return)
// A granted burst reads len+1 sequential bytes starting at addr (wrapping at
// 2^ADDR_W). ROM pins and the return channel are all registered: request seen
// at edge E0 -> gnt and first rom_add in cycle E0+1 -> first rd_valid in E0+2.
// Bursts are separated by at least one IDLE cycle; winners alternate when both
// ports are requesting.
// Optional feature macro: ROM_ADDR_CHECK_EN. When defined, byte addresses at or
// above DEPTH read as 0, keep rom_chip low for that cycle and set sticky err.
module rom_burst_arbiter
  import rom_ctrl_pkg::*;
(
  input logic                clk,
  input logic                rst,
  rom_burst_arbiter_if.slave bus
);

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_last_served;
  logic              w_accept;
  logic              w_burst_end;
  logic [ADDR_W-1:0] w_win_add;
  logic [LEN_W-1:0]  w_win_len;
  logic [ADDR_W-1:0] w_next_add;
  logic [DATA_W-1:0] w_byte;
  logic              w_win_chip;
  logic              w_next_chip;

  state_t            r_state;
  logic [ADDR_W-1:0] r_add;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_chip;
  logic              r_rd_en;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_id;
  logic              r_rd_last;
`ifdef ROM_ADDR_CHECK_EN
  logic              r_err;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH;
  endfunction
`endif

  assign w_req       = {bus.req1, bus.req0};
  assign w_accept    = (r_state == IDLE) && (|w_req);
  assign w_burst_end = (r_cnt == r_len);
  assign w_win_add   = w_grant[1] ? bus.addr1 : bus.addr0;
  assign w_win_len   = w_grant[1] ? bus.len1  : bus.len0;
  // r_add tracks base+cnt directly; natural ADDR_W overflow gives the wrap.
  assign w_next_add  = r_add + ADDR_W'(1);

`ifdef ROM_ADDR_CHECK_EN
  assign w_byte      = addr_ok(r_add) ? bus.rom_dato : '0;
  assign w_win_chip  = addr_ok(w_win_add);
  assign w_next_chip = addr_ok(w_next_add);
`else
  assign w_byte      = bus.rom_dato;
  assign w_win_chip  = 1'b1;
  assign w_next_chip = 1'b1;
`endif

  // The arbiter records the winner at acceptance, so for the whole burst its
  // last-served flag names the owner; it doubles as the burst id.
  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_req),
    .i_advance (w_accept),
    .o_grant   (w_grant),
    .o_last    (w_last_served)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_add      <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_chip     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_id    <= 1'b0;
      r_rd_last  <= 1'b0;
`ifdef ROM_ADDR_CHECK_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        IDLE: begin
          r_rd_valid <= 1'b0;
          r_rd_last  <= 1'b0;
          if (w_accept) begin
            r_state <= READ;
            r_add   <= w_win_add;
            r_len   <= w_win_len;
            r_cnt   <= '0;
            r_gnt0  <= w_grant[0];
            r_gnt1  <= w_grant[1];
            r_chip  <= w_win_chip;
            r_rd_en <= 1'b1;
          end
        end
        READ: begin
          // Return stage: capture the byte addressed during this cycle.
          r_rd_data  <= w_byte;
          r_rd_valid <= 1'b1;
          r_rd_id    <= w_last_served;
          r_rd_last  <= w_burst_end;
`ifdef ROM_ADDR_CHECK_EN
          if (!addr_ok(r_add)) begin
            r_err <= 1'b1;
          end
`endif
          if (w_burst_end) begin
            r_state <= IDLE;
            r_chip  <= 1'b0;
            r_rd_en <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + LEN_W'(1);
            r_add  <= w_next_add;
            r_chip <= w_next_chip;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0        = r_gnt0;
  assign bus.gnt1        = r_gnt1;
  assign bus.rom_add     = r_add;
  assign bus.rom_read_en = r_rd_en;
  assign bus.rom_chip    = r_chip;
  assign bus.rd_data     = r_rd_data;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_id       = r_rd_id;
  assign bus.rd_last     = r_rd_last;
  assign bus.busy        = (r_state == READ);
`ifdef ROM_ADDR_CHECK_EN
  assign bus.err         = r_err;
`endif

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Testbench for rom_burst_arbiter. The ROM is modelled as mem[i] = i[7:0].
// A reference model schedules, per granted burst, the expected cycle-by-cycle
// outputs from the latency rules (gnt at +1, rom_add at +1..+1+len, bytes at
// +2..+2+len, next decision no earlier than +2+len) and compares every cycle.
module tb_rom_burst_arbiter;
  import rom_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold0 = 1'b0;
  logic hold1 = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  rom_burst_arbiter_if bus ();

  rom_burst_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_dato = bus.rom_add[7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model (schedule of expected outputs) -------------
  logic              s_gnt0 [64];
  logic              s_gnt1 [64];
  logic              s_busy [64];
  logic              s_chip [64];
  logic [ADDR_W-1:0] s_add  [64];
  logic              s_vld  [64];
  logic [DATA_W-1:0] s_data [64];
  logic              s_id   [64];
  logic              s_last [64];
  logic              s_err  [64];
  int                cyc = 0;
  int                free_at = 0;
  logic              m_last_served = 1'b1;
  logic [DATA_W-1:0] m_data = '0;
  logic              m_err = 1'b0;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
`ifdef ROM_ADDR_CHECK_EN
    return int'(a) < DEPTH;
`else
    return (a === a);
`endif
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) begin
      s_gnt0[i] = 0; s_gnt1[i] = 0; s_busy[i] = 0; s_chip[i] = 0; s_add[i] = '0;
      s_vld[i] = 0; s_data[i] = '0; s_id[i] = 0; s_last[i] = 0; s_err[i] = 0;
    end
  end

  always @(negedge clk) begin
    int sl;
    int w;
    int ln;
    logic [ADDR_W-1:0] a;
    if (rst) begin
      chk("rst_gnt0", bus.gnt0, 0);
      chk("rst_gnt1", bus.gnt1, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_chip", bus.rom_chip, 0);
      chk("rst_rden", bus.rom_read_en, 0);
      chk("rst_add", bus.rom_add, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_rd_id", bus.rd_id, 0);
      chk("rst_rd_last", bus.rd_last, 0);
`ifdef ROM_ADDR_CHECK_EN
      chk("rst_err", bus.err, 0);
`endif
      for (int i = 0; i < 64; i++) begin
        s_gnt0[i] = 0; s_gnt1[i] = 0; s_busy[i] = 0; s_chip[i] = 0;
        s_vld[i] = 0; s_last[i] = 0; s_err[i] = 0;
      end
      cyc = 0; free_at = 0; m_last_served = 1'b1; m_data = '0; m_err = 1'b0;
    end else begin
      sl = cyc % 64;
      chk("gnt0", bus.gnt0, s_gnt0[sl]);
      chk("gnt1", bus.gnt1, s_gnt1[sl]);
      chk("busy", bus.busy, s_busy[sl]);
      chk("rom_read_en", bus.rom_read_en, s_busy[sl]);
      chk("rom_chip", bus.rom_chip, s_chip[sl]);
      if (s_busy[sl]) chk("rom_add", bus.rom_add, s_add[sl]);
      chk("rd_valid", bus.rd_valid, s_vld[sl]);
      chk("rd_last", bus.rd_last, s_last[sl]);
      if (s_vld[sl]) begin
        m_data = s_data[sl];
        chk("rd_id", bus.rd_id, s_id[sl]);
      end
      chk("rd_data", bus.rd_data, m_data);
`ifdef ROM_ADDR_CHECK_EN
      m_err = m_err | s_err[sl];
      chk("err", bus.err, m_err);
`endif
      s_gnt0[sl] = 0; s_gnt1[sl] = 0; s_busy[sl] = 0; s_chip[sl] = 0;
      s_vld[sl] = 0; s_last[sl] = 0; s_err[sl] = 0;
      // Arbitration for inputs that the coming edge will sample.
      if (cyc >= free_at && (bus.req0 || bus.req1)) begin
        if (bus.req0 && bus.req1) w = m_last_served ? 0 : 1;
        else w = bus.req1 ? 1 : 0;
        ln = (w == 1) ? int'(bus.len1) : int'(bus.len0);
        a  = (w == 1) ? bus.addr1 : bus.addr0;
        m_last_served = (w == 1);
        if (w == 1) s_gnt1[(cyc + 1) % 64] = 1; else s_gnt0[(cyc + 1) % 64] = 1;
        for (int k = 0; k <= ln; k++) begin
          s_busy[(cyc + 1 + k) % 64] = 1;
          s_add [(cyc + 1 + k) % 64] = a;
          s_chip[(cyc + 1 + k) % 64] = in_range(a);
          s_vld [(cyc + 2 + k) % 64] = 1;
          s_data[(cyc + 2 + k) % 64] = in_range(a) ? a[7:0] : 8'h00;
          s_err [(cyc + 2 + k) % 64] = !in_range(a);
          s_id  [(cyc + 2 + k) % 64] = (w == 1);
          s_last[(cyc + 2 + k) % 64] = (k == ln);
          a = a + ADDR_W'(1);
        end
        free_at = cyc + ln + 2;
      end
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.gnt0 && !hold0) bus.req0 = 1'b0;
    if (bus.gnt1 && !hold1) bus.req1 = 1'b0;
  endtask

  task automatic wait_gnt(input int p, input string tag);
    logic seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      seen = (p == 1) ? bus.gnt1 : bus.gnt0;
    end
    chk(tag, seen, 1);
  endtask

  task automatic wait_rd(input string tag, output logic [7:0] d, output logic id, output logic last);
    logic seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      seen = bus.rd_valid;
    end
    chk(tag, seen, 1);
    d = bus.rd_data; id = bus.rd_id; last = bus.rd_last;
  endtask

  task automatic wait_idle(input string tag);
    logic done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      tick();
      done = !bus.busy && !bus.req0 && !bus.req1 && !bus.rd_valid;
    end
    chk(tag, done, 1);
  endtask

  task automatic record_order(output int first, output int second);
    first = -1; second = -1;
    for (int n = 0; n < 100 && (bus.req0 || bus.req1); n++) begin
      tick();
      if (bus.gnt0) begin if (first < 0) first = 0; else second = 0; end
      if (bus.gnt1) begin if (first < 0) first = 1; else second = 1; end
    end
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return ADDR_W'($urandom_range(0, 4095));
      1:       return ADDR_W'(12'hFF0 + ADDR_W'($urandom_range(0, 15)));
      default: return ADDR_W'(12'h0F0 + ADDR_W'($urandom_range(0, 31)));
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] d;
    logic       id;
    logic       last;
    logic [7:0] exp2 [4];
    int         f;
    int         s;
    int         gc;
    int         rc;

    bus.req0 = 0; bus.addr0 = '0; bus.len0 = '0;
    bus.req1 = 0; bus.addr1 = '0; bus.len1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single read
    bus.addr0 = 12'h005; bus.len0 = 4'd0; bus.req0 = 1;
    wait_gnt(0, "t1_gnt0");
    wait_rd("t1_rd_seen", d, id, last);
    chk("t1_data", d, 8'h05);
    chk("t1_id", id, 0);
    chk("t1_last", last, 1);
    wait_idle("t1_idle");

    // Burst across the DEPTH boundary
    exp2[0] = 8'hFE; exp2[1] = 8'hFF;
`ifdef ROM_ADDR_CHECK_EN
    exp2[2] = 8'h00; exp2[3] = 8'h00;
`else
    exp2[2] = 8'h00; exp2[3] = 8'h01;
`endif
    bus.addr1 = 12'h0FE; bus.len1 = 4'd3; bus.req1 = 1;
    wait_gnt(1, "t2_gnt1");
    for (int i = 0; i < 4; i++) begin
      wait_rd("t2_rd_seen", d, id, last);
      chk("t2_data", d, exp2[i]);
      chk("t2_id", id, 1);
      chk("t2_last", last, (i == 3));
    end
`ifdef ROM_ADDR_CHECK_EN
    chk("t2_err", bus.err, 1);
`endif
    wait_idle("t2_idle");

    // Both ports requesting out of reset, then again
    @(posedge clk); #1;
    rst = 1'b1;
    bus.addr0 = 12'h100; bus.len0 = 4'd1; bus.req0 = 1;
    bus.addr1 = 12'h200; bus.len1 = 4'd1; bus.req1 = 1;
    tick();
    rst = 1'b0;
    record_order(f, s);
    chk("t3a_first", f, 0);
    chk("t3a_second", s, 1);
    wait_idle("t3a_idle");
    bus.addr0 = 12'h010; bus.len0 = 4'd2; bus.req0 = 1;
    bus.addr1 = 12'h020; bus.len1 = 4'd0; bus.req1 = 1;
    record_order(f, s);
    chk("t3b_first", f, 0);
    chk("t3b_second", s, 1);
    wait_idle("t3b_idle");

    // Address wrap
    bus.addr0 = 12'hFFF; bus.len0 = 4'd1; bus.req0 = 1;
    wait_gnt(0, "t4_gnt0");
    chk("t4_add0", bus.rom_add, 12'hFFF);
    tick();
    chk("t4_add1", bus.rom_add, 12'h000);
    tick(); tick();
`ifdef ROM_ADDR_CHECK_EN
    chk("t4_err", bus.err, 1);
`endif
    wait_idle("t4_idle");

    // Reset mid-burst
    bus.addr0 = 12'h030; bus.len0 = 4'd15; bus.req0 = 1;
    wait_gnt(0, "t5_gnt0");
    for (int i = 0; i < 3; i++) begin
      wait_rd("t5_rd_seen", d, id, last);
      chk("t5_pre_data", d, 8'h30 + 8'(i));
    end
    rst = 1'b1;
    #1;
    chk("t5_busy", bus.busy, 0);
    chk("t5_rd_valid", bus.rd_valid, 0);
    chk("t5_rd_last", bus.rd_last, 0);
    chk("t5_chip", bus.rom_chip, 0);
    chk("t5_add", bus.rom_add, 0);
    chk("t5_rd_data", bus.rd_data, 0);
    tick(); tick();
    rst = 1'b0;
    bus.addr0 = 12'h020; bus.len0 = 4'd2; bus.req0 = 1;
    wait_gnt(0, "t5_regnt0");
    for (int i = 0; i < 3; i++) begin
      wait_rd("t5_post_seen", d, id, last);
      chk("t5_post_data", d, 8'h20 + 8'(i));
      chk("t5_post_last", last, (i == 2));
    end
    wait_idle("t5_idle");

    // Back-to-back single-byte bursts from a held request
    gc = 0; rc = 0;
    bus.addr0 = 12'h040; bus.len0 = 4'd0; hold0 = 1; bus.req0 = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      gc += int'(bus.gnt0);
      rc += int'(bus.rd_valid);
    end
    bus.req0 = 0; hold0 = 0;
    chk("t6_gnt_count", gc, 6);
    chk("t6_rd_count", rc, 6);
    wait_idle("t6_idle");

    // Randomized traffic on both ports
    for (int c = 0; c < 600; c++) begin
      if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.addr0 = rand_addr(); bus.len0 = LEN_W'($urandom_range(0, 15)); bus.req0 = 1;
      end
      if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.addr1 = rand_addr(); bus.len1 = LEN_W'($urandom_range(0, 15)); bus.req1 = 1;
      end
      tick();
    end
    wait_idle("rand_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
